load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- CPU-side initiator for `data_memory`: accepts one load/store request per transaction from the MEM stage and drives the memory's word-wide port.
- Performs byte/halfword extraction with sign/zero extension on loads.
- Performs read-modify-write for SB/SH, because `data_memory` has only a whole-word write enable.
- Sits between the pipeline MEM stage and `data_memory`.

Parameters:
- ADDR_W, 16, memory word-address width; the byte address is ADDR_W+2 bits.
- DATA_W, 32, data word width; fixed at 32, byte lanes assume 4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  illegal funct3 or misaligned (qualified by resp_valid)
- mem_wEn  out  1  to `data_memory` mem_wEn
- mem_address  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- mem_write_data  out  32  to `data_memory` write_data
- mem_read_data  in  32  from `data_memory` read_data (combinational read of mem_address)

Behaviour:
- Reset (rst=0, async): state=IDLE, mem_wEn=0, mem_address=0, mem_write_data=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 once the FSM is in IDLE.
- FSM states: IDLE, RD, MRG_WR, WR, RESP.
- IDLE:
  - On req_valid&req_ready: latch store, funct3, addr, wdata.
  - Next state is RESP with err if funct3 is illegal: 011/110/111 for loads; anything other than 000/001/010 for stores.
  - Otherwise next is RESP with err if misaligned (see Optional Feature).
  - Otherwise next is WR for SW, else RD.
- RD:
  - mem_address = latched word address, mem_wEn=0.
  - mem_read_data is sampled into an internal word register at the closing edge.
  - Next state is RESP for loads, MRG_WR for SB/SH.
- MRG_WR:
  - mem_wEn=1; mem_write_data = sampled word with the selected lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Lane select: byte lane = addr[1:0], half lane = addr[1].
  - Next state RESP.
- WR: mem_wEn=1, mem_write_data = wdata. Next state RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; no response backpressure.
  - resp_rdata:
    - B: sign-extended byte at lane addr[1:0].
    - BU: zero-extended byte.
    - H/HU: halfword at addr[1], sign- or zero-extended.
    - W: full word.
  - Next state IDLE.
- Latency from the accept edge to resp_valid high: SW 2 cycles, loads 2, SB/SH 3, error 1. Next accept happens in the cycle after RESP.
- mem_wEn is high only in WR/MRG_WR, exactly one cycle per store. No memory write ever occurs on an error.
- mem_address holds the last latched word address outside IDLE transactions (never glitches during WR).
- Reset mid-transaction: immediate return to IDLE and mem_wEn drops combinationally.
  - If rst is asserted before the WR/MRG_WR closing edge, memory is unchanged.
  - The in-flight request is dropped with no response.

Optional Feature:
- Macro LSU_MISALIGN_ERR_EN.
- Defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, produces resp_err=1 with no memory access.
- Undefined: low address bits are forced to alignment (H ignores addr[0], W ignores addr[1:0]) and the access proceeds normally. resp_err then reflects illegal funct3 only.

Decomposition:
- Package rv_mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state encoding localparams.
- Sub-module lsu_align (combinational):
  - Inputs: funct3, addr[1:0], old word, wdata.
  - Outputs: merged store word and extended load data.
  - Instantiated once and shared by MRG_WR and RESP.

Test Plan:
- SW 0x11100011 to byte addr 0x1BC -> exactly one mem_wEn cycle with mem_address=0x006f, resp_valid 2 cycles after accept, resp_err=0.
- LW 0x1BC after the above -> resp_rdata=0x11100011, mem_wEn never high.
- SB 0x000000AB to 0x1BD -> RD then MRG_WR writes 0x1110AB11.
  - A following LB 0x1BD must return 0xFFFFFFAB.
  - A following LBU 0x1BD must return 0x000000AB.
- SH 0xBEEF to 0x1BE, then LH 0x1BE -> 0xFFFFBEEF; LHU 0x1BE -> 0x0000BEEF; word reads 0xBEEFAB11.
- LH 0x1BD:
  - With LSU_MISALIGN_ERR_EN: resp_err=1, resp_rdata=0, no mem access, 1-cycle latency.
  - Without it: returns the sign-extended half at 0x1BC.
- Store with funct3=100 -> resp_err=1, no write.
- rst pulsed low during RD of an SB -> mem_wEn never asserts, word unchanged, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the load/store unit: RISC-V funct3 widths and FSM states.
// Misalignment handling is selected by the LSU_MISALIGN_ERR_EN macro in load_store_unit.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_MRG_WR = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    RD     = ST_RD,
    MRG_WR = ST_MRG_WR,
    WR     = ST_WR,
    RESP   = ST_RESP
  } lsu_state_e;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Clears the address bits below the access size.
  function automatic logic [1:0] f3_align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return {lo[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering shared by the store merge and the load response:
// builds the read-modify-write word and the sign/zero-extended load value.
module lsu_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_ldata
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_sh = {i_addr_lo, 3'b000};
  assign w_half_sh = {i_addr_lo[1], 4'b0000};
  assign w_byte    = i_old_word[w_byte_sh +: 8];
  assign w_half    = i_old_word[w_half_sh +: 16];

  always_comb begin
    o_merged = i_old_word;
    case (i_funct3[1:0])
      2'b00:   o_merged[w_byte_sh +: 8]  = i_wdata[7:0];
      2'b01:   o_merged[w_half_sh +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

  always_comb begin
    o_ldata = '0;
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ldata = {24'b0, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ldata = {16'b0, w_half};
      F3_W:    o_ldata = i_old_word;
      default: o_ldata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for a word-wide data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_ERR_EN to reject misaligned H/W accesses instead of aligning them.
//   state  | meaning
//   IDLE   | ready for a request
//   RD     | read addressed word into r_word
//   MRG_WR | write r_word with SB/SH lane(s) replaced
//   WR     | write full SW word
//   RESP   | one-cycle response pulse
module load_store_unit
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [ADDR_W+1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_word;
  logic              r_err;

  logic              w_accept;
  logic              w_err;
  logic              w_misalign;
  logic [ADDR_W+1:0] w_addr_lat;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_ldata;

  assign w_accept = req_valid && (r_state == IDLE);

`ifdef LSU_MISALIGN_ERR_EN
  assign w_misalign = f3_misaligned(req_funct3, req_addr[1:0]);
  assign w_addr_lat = req_addr;
`else
  assign w_misalign = 1'b0;
  assign w_addr_lat = {req_addr[ADDR_W+1:2], f3_align_lo(req_funct3, req_addr[1:0])};
`endif

  assign w_err = !f3_legal(req_store, req_funct3) || w_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_store  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_addr   <= w_addr_lat;
        r_wdata  <= req_wdata;
        r_err    <= w_err;
      end
      if (r_state == RD) r_word <= mem_read_data;
    end
  end

  lsu_align u_align (
    .i_funct3   (r_funct3),
    .i_addr_lo  (r_addr[1:0]),
    .i_old_word (r_word),
    .i_wdata    (r_wdata),
    .o_merged   (w_merged),
    .o_ldata    (w_ldata)
  );

  // Address comes straight from the latch so it is stable across the write cycle.
  assign mem_address = r_addr[ADDR_W+1:2];

  always_comb begin
    w_state_nxt    = r_state;
    req_ready      = 1'b0;
    mem_wEn        = 1'b0;
    mem_write_data = '0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_err)                               w_state_nxt = RESP;
          else if (req_store && req_funct3 == F3_W) w_state_nxt = WR;
          else                                     w_state_nxt = RD;
        end
      end
      RD:     w_state_nxt = r_store ? MRG_WR : RESP;
      MRG_WR: begin
        mem_wEn        = 1'b1;
        mem_write_data = w_merged;
        w_state_nxt    = RESP;
      end
      WR: begin
        mem_wEn        = 1'b1;
        mem_write_data = r_wdata;
        w_state_nxt    = RESP;
      end
      RESP: begin
        resp_valid  = 1'b1;
        resp_err    = r_err;
        resp_rdata  = (r_err || r_store) ? '0 : w_ldata;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit against a small word memory model.
module tb_load_store_unit;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_store = 1'b0;
  logic [2:0]        req_funct3 = '0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_wEn;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wEn(mem_wEn), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  logic [15:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  assign mem_read_data = mem[mem_address[7:0]];

  always @(posedge clk) begin
    if (mem_wEn === 1'b1) begin
      wr_cnt++;
      last_waddr = mem_address;
      last_wdata = mem_write_data;
      mem[mem_address[7:0]] = mem_write_data;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [17:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int elat, input int ewr);
    exp_t e;
    exp_t got;
    int   lat;
    int   wr0;
    e.rdata = er; e.err = ee; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    got = sb.pop_front();
    chk({tag, "_resp_seen"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, got.rdata);
    chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, got.err});
    chk({tag, "_lat"}, lat, got.lat);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_writes"}, wr_cnt - wr0, ewr);
  endtask

  initial begin
    int   wr0;
    int   resp_seen;
    logic [31:0] word_before;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wEn",   {31'b0, mem_wEn}, 32'd0);
    chk("rst_addr",  {16'b0, mem_address}, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err",   {31'b0, resp_err}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk) rst = 1'b1;

    do_req("sw", 1'b1, 3'b010, 18'h1BC, 32'h11100011, 32'h0, 1'b0, 2, 1);
    chk("sw_waddr", {16'b0, last_waddr}, 32'h0000006F);
    chk("sw_mem", mem[8'h6F], 32'h11100011);
    do_req("lw1", 1'b0, 3'b010, 18'h1BC, 32'h0, 32'h11100011, 1'b0, 2, 0);
    do_req("sb", 1'b1, 3'b000, 18'h1BD, 32'h000000AB, 32'h0, 1'b0, 3, 1);
    chk("sb_wdata", last_wdata, 32'h1110AB11);
    do_req("lb", 1'b0, 3'b000, 18'h1BD, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 0);
    do_req("lbu", 1'b0, 3'b100, 18'h1BD, 32'h0, 32'h000000AB, 1'b0, 2, 0);
    do_req("sh", 1'b1, 3'b001, 18'h1BE, 32'h0000BEEF, 32'h0, 1'b0, 3, 1);
    chk("sh_wdata", last_wdata, 32'hBEEFAB11);
    do_req("lh", 1'b0, 3'b001, 18'h1BE, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0);
    do_req("lhu", 1'b0, 3'b101, 18'h1BE, 32'h0, 32'h0000BEEF, 1'b0, 2, 0);
    do_req("lw2", 1'b0, 3'b010, 18'h1BC, 32'h0, 32'hBEEFAB11, 1'b0, 2, 0);
`ifdef LSU_MISALIGN_ERR_EN
    do_req("lh_mis", 1'b0, 3'b001, 18'h1BD, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    do_req("lh_mis", 1'b0, 3'b001, 18'h1BD, 32'h0, 32'hFFFFAB11, 1'b0, 2, 0);
`endif
    do_req("st_bad", 1'b1, 3'b100, 18'h1BC, 32'hDEADBEEF, 32'h0, 1'b1, 1, 0);
    chk("st_bad_mem", mem[8'h6F], 32'hBEEFAB11);
    do_req("ld_bad", 1'b0, 3'b011, 18'h1BC, 32'h0, 32'h0, 1'b1, 1, 0);

    // SB interrupted by reset while in RD
    word_before = mem[8'h6F];
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 18'h1BD;
    req_wdata = 32'h000000CD;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rstmid_rd_wEn", {31'b0, mem_wEn}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid_wEn", {31'b0, mem_wEn}, 32'd0);
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk) rst = 1'b1;
    resp_seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1 if (resp_valid === 1'b1) resp_seen++;
    end
    chk("rstmid_no_resp", resp_seen, 32'd0);
    chk("rstmid_writes", wr_cnt - wr0, 32'd0);
    chk("rstmid_mem", mem[8'h6F], word_before);
    chk("rstmid_ready2", {31'b0, req_ready}, 32'd1);

    do_req("lw3", 1'b0, 3'b010, 18'h1BC, 32'h0, 32'hBEEFAB11, 1'b0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
